// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit path: frame scheduler state encoding,
// default stream/counter widths and mapper constants.
package qpsk_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 8;
   localparam int PRE_W_DEF  = 4;
   localparam int GAP_W_DEF  = 4;

   // Mapper side: two bits per QPSK symbol.
   localparam int QPSK_BITS_PER_SYM = 2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_GAP      = 2'd3
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int syms_per_word(input int data_w);
      return data_w / QPSK_BITS_PER_SYM;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered stream stage: the only latency between the sources
// and the mapper.
module axis_out_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   // Handshake: a beat moves when valid and ready are both high on a rising edge;
   // once out_valid is high, out_data/out_last hold until out_ready is seen.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         out_last  <= in_valid & in_last;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/qpsk_frame_scheduler.sv
// Builds preamble / payload / gap frames from two source streams into one
// registered stream towards the QPSK mapper.
module qpsk_frame_scheduler
   import qpsk_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int PRE_W  = PRE_W_DEF,
   parameter int GAP_W  = GAP_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_enable,
   input  logic [PRE_W-1:0]  cfg_pre_words,
   input  logic [LEN_W-1:0]  cfg_pay_words,
   input  logic [GAP_W-1:0]  cfg_gap_words,
   input  logic [DATA_W-1:0] cfg_idle_word,
   input  logic [DATA_W-1:0] pre_tdata,
   input  logic              pre_tvalid,
   output logic              pre_tready,
   input  logic [DATA_W-1:0] pay_tdata,
   input  logic              pay_tvalid,
   output logic              pay_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       underrun_cnt,
   output state_t            fsm_state
);

   localparam int CNT_W = max3(LEN_W, PRE_W, GAP_W);

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
   logic [PRE_W-1:0]   sh_pre;
   logic [LEN_W-1:0]   sh_pay;
   logic [GAP_W-1:0]   sh_gap;
   logic [DATA_W-1:0]  sh_idle;

   logic               can;
   logic               load_cfg, frame_done, underrun;
   logic               beat_valid, beat_last;
   logic [DATA_W-1:0]  beat_data;
   logic               start_ok;
   state_t             start_state;
   logic               last_pre, last_pay, last_gap;

   assign start_ok    = cfg_enable && (cfg_pay_words != '0);
   assign start_state = (cfg_pre_words != '0) ? ST_PREAMBLE : ST_PAYLOAD;
   assign cnt_inc     = cnt + CNT_W'(1);
   assign last_pre    = (cnt_inc == CNT_W'(sh_pre));
   assign last_pay    = (cnt_inc == CNT_W'(sh_pay));
   assign last_gap    = (cnt_inc == CNT_W'(sh_gap));
   assign fsm_state   = state;

   axis_out_reg #(.DATA_W(DATA_W)) u_out (
      .clk       (clk),
      .reset     (reset),
      .in_data   (beat_data),
      .in_valid  (beat_valid),
      .in_last   (beat_last),
      .in_ready  (can),
      .out_data  (m_tdata),
      .out_valid (m_tvalid),
      .out_last  (m_tlast),
      .out_ready (m_tready)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         sh_pre       <= '0;
         sh_pay       <= '0;
         sh_gap       <= '0;
         sh_idle      <= '0;
         frame_cnt    <= '0;
         underrun_cnt <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
         if (load_cfg) begin
            sh_pre  <= cfg_pre_words;
            sh_pay  <= cfg_pay_words;
            sh_gap  <= cfg_gap_words;
            sh_idle <= cfg_idle_word;
         end
         if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      load_cfg   = 1'b0;
      frame_done = 1'b0;
      underrun   = 1'b0;
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      beat_data  = '0;
      pre_tready = 1'b0;
      pay_tready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               load_cfg   = 1'b1;
               cnt_next   = '0;
               next_state = start_state;
            end
         end
         ST_PREAMBLE: begin
            pre_tready = can;
            if (pre_tvalid && can) begin
               beat_valid = 1'b1;
               beat_data  = pre_tdata;
               if (last_pre) begin
                  cnt_next   = '0;
                  next_state = ST_PAYLOAD;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         ST_PAYLOAD: begin
            pay_tready = can;
            underrun   = can && !pay_tvalid;
            if (pay_tvalid && can) begin
               beat_valid = 1'b1;
               beat_data  = pay_tdata;
               beat_last  = last_pay;
               if (last_pay) begin
                  frame_done = 1'b1;
                  cnt_next   = '0;
                  // With no gap the next frame starts without a dead cycle.
                  if (sh_gap != '0) begin
                     next_state = ST_GAP;
                  end else if (start_ok) begin
                     load_cfg   = 1'b1;
                     next_state = start_state;
                  end else begin
                     next_state = ST_IDLE;
                  end
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         ST_GAP: begin
            if (can) begin
               beat_valid = 1'b1;
               beat_data  = sh_idle;
               if (last_gap) begin
                  cnt_next = '0;
                  if (start_ok) begin
                     load_cfg   = 1'b1;
                     next_state = start_state;
                  end else begin
                     next_state = ST_IDLE;
                  end
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// Directed bench for qpsk_frame_scheduler: frame table plus hand-written
// sequences for back-to-back frames, underrun, cfg change and mid-frame reset.
module tb_qpsk_frame_scheduler;
   import qpsk_pkg::*;

   localparam int DATA_W = 32;
   localparam logic [31:0] PRE_BASE = 32'h1000_0000;
   localparam logic [31:0] PAY_BASE = 32'h2000_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic              cfg_enable;
   logic [3:0]        cfg_pre_words;
   logic [7:0]        cfg_pay_words;
   logic [3:0]        cfg_gap_words;
   logic [31:0]       cfg_idle_word;
   logic [31:0]       pre_tdata, pay_tdata;
   logic              pre_tvalid, pay_tvalid, pre_tready, pay_tready;
   logic [31:0]       m_tdata;
   logic              m_tvalid, m_tready, m_tlast;
   logic [15:0]       frame_cnt, underrun_cnt;
   state_t            fsm_state;

   qpsk_frame_scheduler dut (
      .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
      .cfg_pre_words(cfg_pre_words), .cfg_pay_words(cfg_pay_words),
      .cfg_gap_words(cfg_gap_words), .cfg_idle_word(cfg_idle_word),
      .pre_tdata(pre_tdata), .pre_tvalid(pre_tvalid), .pre_tready(pre_tready),
      .pay_tdata(pay_tdata), .pay_tvalid(pay_tvalid), .pay_tready(pay_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt), .fsm_state(fsm_state)
   );

   // Clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DATA_W:0] exp_q[$];
   int m_pre_idx = 0, m_pay_idx = 0;
   int pre_idx = 0, pay_idx = 0;
   int pay_hold = 0;
   bit rdy_random = 1'b0;
   int beat_cnt = 0, last_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_frame(input int pre, input int pay, input int gap, input logic [31:0] idle);
      for (int i = 0; i < pre; i++) begin
         exp_q.push_back({1'b0, PRE_BASE + 32'(m_pre_idx)});
         m_pre_idx++;
      end
      for (int i = 0; i < pay; i++) begin
         exp_q.push_back({(i == pay - 1), PAY_BASE + 32'(m_pay_idx)});
         m_pay_idx++;
      end
      for (int i = 0; i < gap; i++) exp_q.push_back({1'b0, idle});
   endtask

   task automatic wait_state(input state_t s, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (fsm_state == s) begin ok = 1'b1; break; end
      end
      check({name, "_reached"}, int'(ok), 1);
   endtask

   task automatic wait_started(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (fsm_state != ST_IDLE) begin ok = 1'b1; break; end
      end
      check({name, "_started"}, int'(ok), 1);
   endtask

   task automatic drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         if (fsm_state == ST_IDLE && !m_tvalid && exp_q.size() == 0) begin ok = 1'b1; break; end
      end
      check({name, "_drained"}, int'(ok), 1);
   endtask

   task automatic set_cfg(input int pre, input int pay, input int gap, input logic [31:0] idle);
      cfg_pre_words = 4'(pre);
      cfg_pay_words = 8'(pay);
      cfg_gap_words = 4'(gap);
      cfg_idle_word = idle;
   endtask

   // Source drivers: a word advances only after the DUT took it.
   initial begin
      bit fire;
      pre_tvalid = 1'b0;
      pre_tdata  = PRE_BASE;
      forever begin
         @(negedge clk); fire = pre_tvalid && pre_tready;
         @(posedge clk); #1;
         if (fire) pre_idx++;
         pre_tvalid = 1'b1;
         pre_tdata  = PRE_BASE + 32'(pre_idx);
      end
   end

   initial begin
      bit fire;
      pay_tvalid = 1'b0;
      pay_tdata  = PAY_BASE;
      forever begin
         @(negedge clk); fire = pay_tvalid && pay_tready;
         @(posedge clk); #1;
         if (fire) pay_idx++;
         pay_tdata = PAY_BASE + 32'(pay_idx);
         if (pay_hold > 0) begin
            pay_tvalid = 1'b0;
            pay_hold--;
         end else begin
            pay_tvalid = 1'b1;
         end
      end
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_tready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard and stall-stability monitor.
   initial begin
      logic [DATA_W:0] exp, held;
      bit stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               checks++;
               if (!m_tvalid || {m_tlast, m_tdata} != held) begin
                  errors++;
                  $display("FAIL stall_hold: got v=%0b %h, expected v=1 %h", m_tvalid, {m_tlast, m_tdata}, held);
               end
            end
            if (m_tvalid && m_tready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL beat_unexpected: got %h, expected no beat", {m_tlast, m_tdata});
               end else begin
                  exp = exp_q.pop_front();
                  if ({m_tlast, m_tdata} != exp) begin
                     errors++;
                     $display("FAIL beat_data: got last=%0b %h, expected last=%0b %h",
                              m_tlast, m_tdata, exp[DATA_W], exp[DATA_W-1:0]);
                  end
               end
               beat_cnt++;
               if (m_tlast) last_cnt++;
               if (beat_cnt == 1) first_cyc = cyc;
               last_cyc = cyc;
            end
            stall_prev = m_tvalid && !m_tready;
            held = {m_tlast, m_tdata};
         end
      end
   end

   typedef struct {
      int          pre, pay, gap;
      logic [31:0] idle;
      bit          rnd;
      int          exp_beats, exp_lasts, exp_frames, exp_span;
   } vec_t;
   vec_t tbl[6];

   initial begin
      logic [15:0] base_fc, base_ur;
      tbl[0] = '{2, 4, 1, 32'hA5A5A5A5, 1'b0, 7, 1, 1, 6};
      tbl[1] = '{0, 3, 2, 32'h0000FFFF, 1'b0, 5, 1, 1, 4};
      tbl[2] = '{3, 5, 0, 32'h12345678, 1'b1, 8, 1, 1, -1};
      tbl[3] = '{1, 1, 3, 32'hCAFEF00D, 1'b1, 5, 1, 1, -1};
      tbl[4] = '{15, 2, 15, 32'h5A5A0000, 1'b0, 32, 1, 1, 31};
      tbl[5] = '{0, 255, 0, 32'h0, 1'b0, 255, 1, 1, 254};

      reset = 1'b1;
      cfg_enable = 1'b0;
      set_cfg(0, 0, 0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", int'(m_tvalid), 0);
      check("rst_m_tdata", int'(m_tdata), 0);
      check("rst_m_tlast", int'(m_tlast), 0);
      check("rst_readies", int'({pre_tready, pay_tready}), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      check("rst_underrun", int'(underrun_cnt), 0);
      check("rst_state", int'(fsm_state), int'(ST_IDLE));
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Zero payload length never starts a frame.
      beat_cnt = 0;
      set_cfg(2, 0, 1, 32'h1);
      cfg_enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("pay0_outputs", int'({pre_tready, pay_tready, m_tvalid}), 0);
         check("pay0_state", int'(fsm_state), int'(ST_IDLE));
      end
      check("pay0_beats", beat_cnt, 0);
      cfg_enable = 1'b0;
      @(posedge clk); #1;

      for (int e = 0; e < 6; e++) begin
         beat_cnt = 0; last_cnt = 0;
         base_fc = frame_cnt; base_ur = underrun_cnt;
         push_frame(tbl[e].pre, tbl[e].pay, tbl[e].gap, tbl[e].idle);
         set_cfg(tbl[e].pre, tbl[e].pay, tbl[e].gap, tbl[e].idle);
         rdy_random = tbl[e].rnd;
         cfg_enable = 1'b1;
         wait_started($sformatf("vec%0d", e));
         cfg_enable = 1'b0;
         drain($sformatf("vec%0d", e));
         rdy_random = 1'b0;
         check($sformatf("vec%0d_beats", e), beat_cnt, tbl[e].exp_beats);
         check($sformatf("vec%0d_lasts", e), last_cnt, tbl[e].exp_lasts);
         check($sformatf("vec%0d_frames", e), int'(16'(frame_cnt - base_fc)), tbl[e].exp_frames);
         check($sformatf("vec%0d_underrun", e), int'(16'(underrun_cnt - base_ur)), 0);
         if (tbl[e].exp_span >= 0)
            check($sformatf("vec%0d_span", e), last_cyc - first_cyc, tbl[e].exp_span);
      end

      // Back-to-back single-word frames: frame_cnt steps every cycle.
      beat_cnt = 0; last_cnt = 0;
      base_fc = frame_cnt;
      for (int i = 0; i < 7; i++) push_frame(0, 1, 0, 32'h0);
      set_cfg(0, 1, 0, 32'h0);
      cfg_enable = 1'b1;
      wait_started("b2b");
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         check($sformatf("b2b_frame_cnt%0d", i), int'(frame_cnt), int'(16'(base_fc + 16'(i))));
      end
      cfg_enable = 1'b0;
      drain("b2b");
      check("b2b_beats", beat_cnt, 7);
      check("b2b_lasts", last_cnt, 7);
      check("b2b_span", last_cyc - first_cyc, 6);

      // Payload source stalls for five cycles mid-payload.
      beat_cnt = 0; last_cnt = 0;
      base_fc = frame_cnt; base_ur = underrun_cnt;
      push_frame(1, 8, 1, 32'hDEAD0001);
      set_cfg(1, 8, 1, 32'hDEAD0001);
      cfg_enable = 1'b1;
      wait_started("urun");
      cfg_enable = 1'b0;
      wait_state(ST_PAYLOAD, "urun_payload");
      repeat (2) @(posedge clk);
      @(negedge clk);
      pay_hold = 5;
      drain("urun");
      check("urun_count", int'(16'(underrun_cnt - base_ur)), 5);
      check("urun_beats", beat_cnt, 10);
      check("urun_frames", int'(16'(frame_cnt - base_fc)), 1);

      // Payload length changed mid-frame only affects the next frame.
      beat_cnt = 0; last_cnt = 0;
      base_fc = frame_cnt;
      push_frame(1, 4, 2, 32'h0BAD0BAD);
      push_frame(1, 8, 2, 32'h0BAD0BAD);
      set_cfg(1, 4, 2, 32'h0BAD0BAD);
      cfg_enable = 1'b1;
      wait_started("cfgchg");
      cfg_pay_words = 8'd8;
      begin
         bit ok = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (frame_cnt == 16'(base_fc + 16'd1)) begin ok = 1'b1; break; end
         end
         check("cfgchg_first_done", int'(ok), 1);
      end
      wait_state(ST_PREAMBLE, "cfgchg_second");
      cfg_enable = 1'b0;
      drain("cfgchg");
      check("cfgchg_beats", beat_cnt, 18);
      check("cfgchg_lasts", last_cnt, 2);
      check("cfgchg_frames", int'(16'(frame_cnt - base_fc)), 2);

      // Reset during payload beat 2 aborts the frame.
      beat_cnt = 0; last_cnt = 0;
      push_frame(2, 6, 1, 32'h77777777);
      set_cfg(2, 6, 1, 32'h77777777);
      cfg_enable = 1'b1;
      wait_started("abort");
      cfg_enable = 1'b0;
      wait_state(ST_PAYLOAD, "abort_payload");
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("abort_m_tvalid", int'(m_tvalid), 0);
      check("abort_m_tdata", int'(m_tdata), 0);
      check("abort_m_tlast", int'(m_tlast), 0);
      check("abort_readies", int'({pre_tready, pay_tready}), 0);
      check("abort_frame_cnt", int'(frame_cnt), 0);
      check("abort_underrun", int'(underrun_cnt), 0);
      check("abort_state", int'(fsm_state), int'(ST_IDLE));
      check("abort_lasts", last_cnt, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      m_pre_idx = pre_idx;
      m_pay_idx = pay_idx;
      beat_cnt = 0; last_cnt = 0;
      push_frame(2, 2, 0, 32'h0);
      set_cfg(2, 2, 0, 32'h0);
      cfg_enable = 1'b1;
      wait_started("restart");
      check("restart_state", int'(fsm_state), int'(ST_PREAMBLE));
      cfg_enable = 1'b0;
      drain("restart");
      check("restart_beats", beat_cnt, 4);
      check("restart_lasts", last_cnt, 1);
      check("restart_frame_cnt", int'(frame_cnt), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qpsk_frame_scheduler.md
QPSK_FRAME_SCHEDULER -- requirements
Module: qpsk_frame_scheduler

Interface
REQ-001 SHALL have parameters, one per line: DATA_W, default 32, stream word width; LEN_W, default 8, payload length counter width; PRE_W, default 4, preamble length counter width; GAP_W, default 4, gap length counter width.
REQ-002 SHALL have port clk, input, 1, clock; all logic SHALL be sampled on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port cfg_enable, input, 1, permits new frames to start.
REQ-005 SHALL have port cfg_pre_words, input, PRE_W, preamble words per frame.
REQ-006 SHALL have port cfg_pay_words, input, LEN_W, payload words per frame.
REQ-007 SHALL have port cfg_gap_words, input, GAP_W, idle words after each frame.
REQ-008 SHALL have port cfg_idle_word, input, DATA_W, fill pattern for gap words.
REQ-009 SHALL have ports pre_tdata (input, DATA_W), pre_tvalid (input, 1) and pre_tready (output, 1), forming the preamble source stream.
REQ-010 SHALL have ports pay_tdata (input, DATA_W), pay_tvalid (input, 1) and pay_tready (output, 1), forming the payload source stream.
REQ-011 SHALL have ports m_tdata (output, DATA_W), m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1), forming the stream to the QPSK mapper.
REQ-012 SHALL have ports frame_cnt (output, 16, completed frames, wrapping) and underrun_cnt (output, 16, payload stall cycles, saturating).

Function
REQ-013 SHALL implement FSM states IDLE, PREAMBLE, PAYLOAD and GAP.
REQ-014 SHALL, in IDLE, start a frame when cfg_enable=1 and cfg_pay_words!=0: latch all cfg_* values into shadow registers; go to PREAMBLE, or to PAYLOAD if cfg_pre_words==0.
REQ-015 SHALL stay in IDLE while cfg_pay_words==0, with no outputs asserted.
REQ-016 SHALL use a single registered output stage: a beat is accepted from the active source when that source's valid=1 and (m_tvalid==0 or m_tready==1); the accepted word appears on m_tdata one cycle later.
REQ-017 SHALL hold m_tdata, m_tvalid and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-018 SHALL assert pre_tready only in PREAMBLE and pay_tready only in PAYLOAD, each gated by (m_tvalid==0 or m_tready==1); both SHALL never be asserted in the same cycle.
REQ-019 SHALL, in PREAMBLE, forward exactly the shadow pre_words count of beats, then go to PAYLOAD.
REQ-020 SHALL, in PAYLOAD, forward exactly the shadow pay_words count of beats; the last payload beat SHALL carry m_tlast=1, and on accepting it frame_cnt SHALL increment (wrapping 0xFFFF->0).
REQ-021 SHALL, after the last payload beat, go to GAP, or directly to frame start/IDLE if shadow gap_words==0.
REQ-022 SHALL, in GAP, emit the shadow gap_words count of beats of shadow idle_word with m_tlast=0, without requiring a source valid.
REQ-023 SHALL, at the end of GAP, start the next frame immediately (re-latching cfg_*) if cfg_enable=1 and cfg_pay_words!=0, else go to IDLE.
REQ-024 SHALL increment underrun_cnt, saturating at 0xFFFF, in each PAYLOAD cycle with pay_tvalid=0 while the output stage can accept a beat.
REQ-025 SHALL, on cfg_enable deassertion mid-frame, complete the current frame and its gap, then go to IDLE.
REQ-026 SHALL ignore cfg_* changes mid-frame; only the shadow registers are used.
REQ-027 SHALL add no further latency beyond the single output register: one beat per cycle is sustained when sources are valid and m_tready=1.

Reset
REQ-028 SHALL, on reset, force state=IDLE, all counters and shadow registers to 0, and m_tdata=0, m_tvalid=0, m_tlast=0, pre_tready=0, pay_tready=0, frame_cnt=0 and underrun_cnt=0.
REQ-029 SHALL treat reset asserted mid-frame as an immediate abort: the partial frame is discarded and no m_tlast is emitted for it.

Structure
REQ-030 SHALL place the state encoding and the default widths (DATA_W, LEN_W, PRE_W, GAP_W) in the shared package qpsk_pkg, alongside the mapper constants.
REQ-031 SHALL implement the output register as one sub-module, axis_out_reg, with a valid/ready holding register; all remaining logic SHALL be in a single FSM body.

Verification
REQ-032 SHALL cover: pre=2, pay=4, gap=1, idle=0xA5A5A5A5, sources always valid, m_tready=1 -> 7 beats on consecutive cycles, m_tlast on beat 6, frame_cnt=1.
REQ-033 SHALL cover: pre=0, pay=1, gap=0, cfg_enable held at 1 -> back-to-back frames with m_tlast on every beat and frame_cnt incrementing each cycle.
REQ-034 SHALL cover: m_tready toggling 1-0-1 randomly -> no beats lost or duplicated, and m_tdata stable while stalled.
REQ-035 SHALL cover: pay_tvalid low for 5 cycles mid-payload -> underrun_cnt=5 and frame content intact.
REQ-036 SHALL cover: cfg_pay_words changed from 4 to 8 mid-frame -> current frame has 4 payload beats and the next frame has 8.
REQ-037 SHALL cover: reset pulse during PAYLOAD beat 2 -> all outputs 0 next cycle, and a new frame restarts cleanly with preamble first.
